hazard_ctrl: RTL

- Pipeline control block for the 5-stage RISC-V core with I-cache.
- Drives the clear, stall and miss_flush inputs of the pipeline registers, including the ID/EX register's clr and miss_flush, and the EX-stage forwarding muxes.
- Contains the I-cache miss/refill FSM, which handshakes with instruction memory and freezes the front end until the line is filled.

---
 rtl/hazard_ctrl_if.sv | 26 ++
 rtl/hazard_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Refill handshake between the hazard/miss controller and instruction memory.
// redirect_pend is carried alongside the handshake for debug visibility.
interface hazard_ctrl_if #(
   parameter int LINE_WORDS = 4
);
   localparam int IW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

   logic          mem_req;
   logic          mem_ack;
   logic [IW-1:0] refill_idx;
   logic          redirect_pend;

   modport master (
      output mem_req,
      output refill_idx,
      output redirect_pend,
      input  mem_ack
   );

   modport slave (
      input  mem_req,
      input  refill_idx,
      input  redirect_pend,
      output mem_ack
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control and I-cache miss/refill FSM for the 5-stage core.
// FORWARD_EN: defined = EX bypass muxes, undefined = RAW stalls instead.
module hazard_ctrl #(
   parameter int         LINE_WORDS = 4,
   parameter logic [2:0] LOAD_CODE  = 3'b001
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  Rs1D,
   input  logic [4:0]  Rs2D,
   input  logic [4:0]  Rs1E,
   input  logic [4:0]  Rs2E,
   input  logic [4:0]  RdE,
   input  logic [4:0]  RdM,
   input  logic [4:0]  RdW,
   input  logic        RegwriteE,
   input  logic        RegwriteM,
   input  logic        RegwriteW,
   input  logic [2:0]  resultsrcE,
   input  logic        PCSrcE,
   input  logic        icache_hit,
   hazard_ctrl_if.master mem,
   output logic [1:0]  ForwardAE,
   output logic [1:0]  ForwardBE,
   output logic        stallF,
   output logic        stallD,
   output logic        flushD,
   output logic        flushE,
   output logic        miss_flush
);
   localparam int IW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
   localparam logic [IW-1:0] LAST = IW'(LINE_WORDS - 1);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DONE
   } state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          req_q, req_d;
   logic          mflush_q, mflush_d;
   logic          pend_q, pend_d;

   logic lw_stall;
   logic raw_stall;
   logic miss_active;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         req_q    <= 1'b0;
         mflush_q <= 1'b0;
         pend_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         req_q    <= req_d;
         mflush_q <= mflush_d;
         pend_q   <= pend_d;
      end
   end

   // A redirect never aborts the refill; the fetched line stays valid.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      req_d    = req_q;
      mflush_d = 1'b0;
      pend_d   = pend_q;
      unique case (state_q)
         IDLE: begin
            req_d = 1'b0;
            if (!icache_hit) begin
               state_d = REQ;
               idx_d   = '0;
               req_d   = 1'b1;
            end
         end
         REQ: begin
            req_d = 1'b1;
            if (PCSrcE) pend_d = 1'b1;
            if (mem.mem_ack) begin
               if (idx_q == LAST) begin
                  state_d  = DONE;
                  req_d    = 1'b0;
                  mflush_d = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            idx_d   = '0;
            req_d   = 1'b0;
            pend_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
            req_d   = 1'b0;
         end
      endcase
   end

   assign mem.mem_req       = req_q;
   assign mem.refill_idx    = idx_q;
   assign mem.redirect_pend = pend_q;
   assign miss_flush        = mflush_q;

   assign lw_stall = (resultsrcE == LOAD_CODE) && (RdE != 5'd0)
                   && ((RdE == Rs1D) || (RdE == Rs2D));

`ifdef FORWARD_EN
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
      logic [1:0] sel;
      sel = 2'b00;
      unique case (1'b1)
         (RegwriteM && RdM != 5'd0 && RdM == rs): sel = 2'b10;
         (RegwriteW && RdW != 5'd0 && RdW == rs): sel = 2'b01;
         default:                                 sel = 2'b00;
      endcase
      return sel;
   endfunction

   assign ForwardAE = fwd_sel(Rs1E);
   assign ForwardBE = fwd_sel(Rs2E);
   assign raw_stall = 1'b0;

   logic unused_raw;
   assign unused_raw = RegwriteE;
`else
   // W needs no check: the register file writes on the falling edge.
   assign ForwardAE = 2'b00;
   assign ForwardBE = 2'b00;
   assign raw_stall =
      (RegwriteE && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D)) ||
      (RegwriteM && RdM != 5'd0 && (RdM == Rs1D || RdM == Rs2D));

   logic unused_fwd;
   assign unused_fwd = ^{Rs1E, Rs2E, RdW, RegwriteW};
`endif

   assign miss_active = (state_q != IDLE) || !icache_hit;

   assign stallF = lw_stall | raw_stall | miss_active;
   assign stallD = lw_stall | raw_stall | miss_active;
   assign flushD = PCSrcE | miss_active;
   assign flushE = lw_stall | raw_stall | PCSrcE;
endmodule
